// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port among three requesters.
// The CPU memory stage can read and write, the UART loader only writes, and
// the user read-out path only reads.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU access; cpu_stall is asserted when the CPU loses
//   cpu_rdata/cpu_rvalid     CPU read return: data plus a one-cycle valid pulse
//   uart_req/addr/wdata      UART write; uart_gnt is asserted when it is accepted
//   usr_req/addr             user read request
//   usr_rdata/usr_rvalid     user read return: data plus a one-cycle valid pulse
//   mem_we/addr/wdata        memory port driven by the winning requester
//   mem_rdata                memory read data, one cycle after the address
//   owner                    current grant: 0 none, 1 CPU, 2 UART, 3 USR
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned UART_BURST = 4,
  parameter int unsigned USR_AGE    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              uart_req,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic              uart_gnt,
  input  logic              usr_req,
  input  logic [ADDR_W-1:0] usr_addr,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              usr_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_UART = 2'd2;
  localparam logic [1:0] OWN_USR  = 2'd3;

  localparam int unsigned BURST_W = $clog2(UART_BURST + 1);
  localparam int unsigned AGE_W   = $clog2(USR_AGE + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(UART_BURST);
  localparam logic [AGE_W-1:0]   AGE_MAX   = AGE_W'(USR_AGE - 1);

  logic [BURST_W-1:0] burst_cnt;
  logic [AGE_W-1:0]   age_cnt;
  logic [1:0]         rd_tag;
  logic [1:0]         grant;

  // Priority order: an aged USR read first, then UART unless it has used up
  // its burst while the CPU waits, then the CPU, then any remaining requester.
  always_comb begin
    grant = OWN_NONE;
    if (usr_req && age_cnt == AGE_MAX)
      grant = OWN_USR;
    else if (uart_req && !(cpu_req && burst_cnt == BURST_MAX))
      grant = OWN_UART;
    else if (cpu_req)
      grant = OWN_CPU;
    else if (uart_req)
      grant = OWN_UART;
    else if (usr_req)
      grant = OWN_USR;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_UART: begin
        mem_we    = 1'b1;
        mem_addr  = uart_addr;
        mem_wdata = uart_wdata;
      end
      OWN_USR: begin
        mem_addr  = usr_addr;
      end
      default: ;
    endcase
  end

  assign owner     = grant;
  assign uart_gnt  = (grant == OWN_UART);
  assign cpu_stall = cpu_req && (grant != OWN_CPU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (!uart_req || grant == OWN_CPU) begin
      burst_cnt <= '0;
    end else if (grant == OWN_UART && cpu_req && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_cnt <= '0;
    end else if (!usr_req || grant == OWN_USR) begin
      age_cnt <= '0;
    end else if (age_cnt != AGE_MAX) begin
      age_cnt <= age_cnt + AGE_W'(1);
    end
  end

  // The tag marks which requester owns the read data that appears on
  // mem_rdata in the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag <= OWN_NONE;
    end else if (grant == OWN_CPU && !cpu_we) begin
      rd_tag <= OWN_CPU;
    end else if (grant == OWN_USR) begin
      rd_tag <= OWN_USR;
    end else begin
      rd_tag <= OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      usr_rdata  <= '0;
      usr_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= (rd_tag == OWN_CPU);
      usr_rvalid <= (rd_tag == OWN_USR);
      if (rd_tag == OWN_CPU) cpu_rdata <= mem_rdata;
      if (rd_tag == OWN_USR) usr_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              uart_req;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic              uart_gnt;
  logic              usr_req;
  logic [ADDR_W-1:0] usr_addr;
  logic [DATA_W-1:0] usr_rdata;
  logic              usr_rvalid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .UART_BURST(4), .USR_AGE(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_gnt(uart_gnt),
    .usr_req(usr_req), .usr_addr(usr_addr), .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory macro: read data for the address presented one cycle earlier.
  // Address 0x0010 holds A5..A5; every other address holds its own value
  // replicated across the word.
  logic [ADDR_W-1:0] rd_addr_q = '0;
  always @(posedge clk) rd_addr_q <= mem_addr;
  assign mem_rdata = (rd_addr_q == 16'h0010) ? {16{8'hA5}} : {8{rd_addr_q}};

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] burst_seq [10];

  initial begin
    burst_seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
    uart_req = 1'b1; uart_addr = 16'h0100; uart_wdata = {4{32'hDEADBEEF}};
    usr_req = 1'b1; usr_addr = 16'h0042;

    // Reset held with requests active.
    tick; tick; tick;
    chk("rst_cpu_rvalid", 128'(cpu_rvalid), 128'd0);
    chk("rst_usr_rvalid", 128'(usr_rvalid), 128'd0);
    chk("rst_cpu_rdata", cpu_rdata, '0);
    chk("rst_usr_rdata", usr_rdata, '0);
    cpu_req = 1'b0; uart_req = 1'b0; usr_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("idle_owner", 128'(owner), 128'd0);
    chk("idle_mem_we", 128'(mem_we), 128'd0);
    chk("idle_mem_addr", 128'(mem_addr), 128'd0);

    // Single CPU read of 0x0010.
    tick;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    chk("cpu_rd_owner", 128'(owner), 128'd1);
    chk("cpu_rd_stall", 128'(cpu_stall), 128'd0);
    chk("cpu_rd_mem_addr", 128'(mem_addr), 128'h10);
    chk("cpu_rd_mem_we", 128'(mem_we), 128'd0);
    tick;
    cpu_req = 1'b0;
    #1;
    chk("cpu_rd_c1_rvalid", 128'(cpu_rvalid), 128'd0);
    tick;
    chk("cpu_rd_c2_rvalid", 128'(cpu_rvalid), 128'd1);
    chk("cpu_rd_c2_rdata", cpu_rdata, {16{8'hA5}});
    chk("cpu_rd_c2_usr_rvalid", 128'(usr_rvalid), 128'd0);
    tick;
    chk("cpu_rd_c3_rvalid", 128'(cpu_rvalid), 128'd0);
    chk("cpu_rd_c3_hold", cpu_rdata, {16{8'hA5}});

    // UART burst limit against a waiting CPU write stream.
    uart_req = 1'b1; uart_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = {4{32'h12345678}};
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("burst_owner_%0d", i), 128'(owner), 128'(burst_seq[i]));
      chk($sformatf("burst_stall_%0d", i), 128'(cpu_stall), 128'(burst_seq[i] == 2'd2));
      chk($sformatf("burst_mem_we_%0d", i), 128'(mem_we), 128'd1);
      tick;
    end
    uart_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

    // UART alone: always granted, writes its own data.
    tick;
    uart_req = 1'b1; uart_addr = 16'h0200;
    #1;
    chk("uart_only_gnt", 128'(uart_gnt), 128'd1);
    chk("uart_only_addr", 128'(mem_addr), 128'h200);
    chk("uart_only_wdata", mem_wdata, {4{32'hDEADBEEF}});
    tick;
    uart_req = 1'b0;

    // USR read ages behind a CPU read stream and wins on its 8th pending cycle.
    tick;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    usr_req = 1'b1; usr_addr = 16'h0042;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("age_owner_%0d", k), 128'(owner), (k == 8) ? 128'd3 : 128'd1);
      tick;
    end
    usr_req = 1'b0; cpu_req = 1'b0;
    #1;
    chk("age_c9_usr_rvalid", 128'(usr_rvalid), 128'd0);
    chk("age_c9_cpu_rvalid", 128'(cpu_rvalid), 128'd1);
    tick;
    chk("age_c10_usr_rvalid", 128'(usr_rvalid), 128'd1);
    chk("age_c10_usr_rdata", usr_rdata, {8{16'h0042}});
    chk("age_c10_cpu_rvalid", 128'(cpu_rvalid), 128'd0);
    chk("age_c10_cpu_rdata", cpu_rdata, {8{16'h0030}});

    // Back-to-back reads: CPU then USR.
    tick;
    cpu_req = 1'b1; cpu_addr = 16'h0055;
    #1;
    chk("b2b_t_owner", 128'(owner), 128'd1);
    tick;
    cpu_req = 1'b0; usr_req = 1'b1; usr_addr = 16'h0066;
    #1;
    chk("b2b_t1_owner", 128'(owner), 128'd3);
    tick;
    usr_req = 1'b0;
    #1;
    chk("b2b_t2_cpu_rvalid", 128'(cpu_rvalid), 128'd1);
    chk("b2b_t2_cpu_rdata", cpu_rdata, {8{16'h0055}});
    chk("b2b_t2_usr_rvalid", 128'(usr_rvalid), 128'd0);
    tick;
    chk("b2b_t3_usr_rvalid", 128'(usr_rvalid), 128'd1);
    chk("b2b_t3_usr_rdata", usr_rdata, {8{16'h0066}});
    chk("b2b_t3_cpu_rvalid", 128'(cpu_rvalid), 128'd0);
    chk("b2b_t3_cpu_hold", cpu_rdata, {8{16'h0055}});

    // Reset lands while a CPU read is in flight.
    tick;
    cpu_req = 1'b1; cpu_addr = 16'h0077;
    #1;
    chk("rstfl_owner", 128'(owner), 128'd1);
    tick;
    cpu_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstfl_cpu_rdata", cpu_rdata, '0);
    chk("rstfl_usr_rdata", usr_rdata, '0);
    tick; tick;
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      chk($sformatf("rstfl_post_rvalid_%0d", j), 128'(cpu_rvalid), 128'd0);
      chk($sformatf("rstfl_post_rdata_%0d", j), cpu_rdata, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
